// File: rtl/nfault_control_fsm.sv
// Multi-channel nFault controller: waits for a bus transaction to settle, picks the addressed
// subsystem and releases or drives the shared open-drain nFault line with its sticky fault.
module nfault_control_fsm #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              register_address_valid,
  input  logic [NUM_CH-1:0] subsystem_enable,
  input  logic [NUM_CH-1:0] fault_in,
  input  logic [NUM_CH-1:0] fault_clear,
  output logic              set_nFault_z,
  output logic              set_nFault_value,
  output logic              nFault_level,
  output logic [NUM_CH-1:0] fault_status,
  output logic [ChW-1:0]    active_channel,
  output logic              select_error,
  output logic              timeout_error
);

  // One counter serves both the settle and the wait-low phases; it never needs to exceed the
  // larger of the two last-count values.
  localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StSettle,
    StCheck,
    StRelease,
    StWaitLow,
    StDrive,
    StError,
    StTimeout,
    StDrain
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic            en_any;
  logic            en_many;
  logic [ChW-1:0]  en_idx;

  always_comb begin
    en_any  = 1'b0;
    en_many = 1'b0;
    en_idx  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (subsystem_enable[i]) begin
        if (en_any) en_many = 1'b1;
        en_any = 1'b1;
        en_idx = ChW'(i);
      end
    end
  end

  // Set wins over clear when both arrive in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_status <= '0;
    end else begin
      fault_status <= (fault_status & ~fault_clear) | fault_in;
    end
  end

  // Pulse outputs are registered on the transition into their state, so each is high for
  // exactly the one cycle the machine spends there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      set_nFault_z     <= 1'b0;
      set_nFault_value <= 1'b0;
      select_error     <= 1'b0;
      timeout_error    <= 1'b0;
      nFault_level     <= 1'b1;
      active_channel   <= '0;
    end else begin
      set_nFault_z     <= 1'b0;
      set_nFault_value <= 1'b0;
      select_error     <= 1'b0;
      timeout_error    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (register_address_valid) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) state_q <= StCheck;
          else                     cnt_q   <= cnt_q + CntW'(1);
        end
        StCheck: begin
          if (!en_any) begin
            state_q      <= StRelease;
            set_nFault_z <= 1'b1;
          end else if (en_many) begin
            state_q      <= StError;
            select_error <= 1'b1;
            set_nFault_z <= 1'b1;
          end else begin
            state_q        <= StWaitLow;
            active_channel <= en_idx;
            cnt_q          <= '0;
          end
        end
        StRelease, StDrive: state_q <= StIdle;
        StWaitLow: begin
          if (!register_address_valid) begin
            state_q          <= StDrive;
            nFault_level     <= ~fault_status[active_channel];
            set_nFault_value <= 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast)) begin
            state_q       <= StTimeout;
            timeout_error <= 1'b1;
            set_nFault_z  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StError, StTimeout: state_q <= StDrain;
        StDrain: begin
          if (!register_address_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nfault_control_fsm.sv
// Bench for nfault_control_fsm: procedural transaction model compared every cycle, directed
// scenarios with literal timing checks, then randomized traffic with occasional resets.
module tb_nfault_control_fsm;

  localparam int NumCh   = 4;
  localparam int Settle  = 3;
  localparam int Timeout = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid = 1'b0;
  logic [NumCh-1:0] en = '0;
  logic [NumCh-1:0] fin = '0;
  logic [NumCh-1:0] fclr = '0;
  logic             set_z, set_v, lvl, sel_err, to_err;
  logic [NumCh-1:0] status;
  logic [1:0]       ch;

  int vectors = 0;
  int miscompares = 0;

  nfault_control_fsm #(
    .NUM_CH        (NumCh),
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .register_address_valid(valid),
    .subsystem_enable      (en),
    .fault_in              (fin),
    .fault_clear           (fclr),
    .set_nFault_z          (set_z),
    .set_nFault_value      (set_v),
    .nFault_level          (lvl),
    .fault_status          (status),
    .active_channel        (ch),
    .select_error          (sel_err),
    .timeout_error         (to_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic             m_z = 1'b0, m_v = 1'b0, m_sel = 1'b0, m_to = 1'b0, m_level = 1'b1;
  logic [1:0]       m_ch = '0;
  logic [NumCh-1:0] m_status;
  bit               ab = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_status <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (fin[i])       m_status[i] <= 1'b1;
        else if (fclr[i]) m_status[i] <= 1'b0;
      end
    end
  end

  // Advance one clock edge; pulses last a single cycle, reset aborts the transaction.
  task automatic tick();
    @(posedge clk or negedge reset);
    m_z = 1'b0; m_v = 1'b0; m_sel = 1'b0; m_to = 1'b0;
    if (!reset) ab = 1'b1;
  endtask

  task automatic drain();
    tick();
    if (ab) return;
    forever begin
      tick();
      if (ab || !valid) return;
    end
  endtask

  task automatic run_txn();
    int n, idx, c;
    forever begin
      tick();
      if (ab) return;
      if (valid) break;
    end
    repeat (Settle) begin
      tick();
      if (ab) return;
    end
    tick();
    if (ab) return;
    n = 0; idx = 0;
    for (int i = 0; i < NumCh; i++) if (en[i]) begin n++; idx = i; end
    if (n == 0) begin m_z = 1'b1; tick(); return; end
    if (n > 1) begin m_sel = 1'b1; m_z = 1'b1; drain(); return; end
    m_ch = 2'(idx);
    c = 0;
    forever begin
      tick();
      if (ab) return;
      if (!valid) begin
        m_level = ~m_status[m_ch];
        m_v = 1'b1;
        tick();
        return;
      end
      c++;
      if (c == Timeout) begin m_to = 1'b1; m_z = 1'b1; drain(); return; end
    end
  endtask

  initial begin
    forever begin
      wait (reset === 1'b1);
      ab = 1'b0;
      while (!ab) run_txn();
      m_z = 1'b0; m_v = 1'b0; m_sel = 1'b0; m_to = 1'b0; m_level = 1'b1; m_ch = '0;
    end
  end

  always @(negedge clk) begin
    chk("set_nFault_z", 32'(set_z), 32'(m_z));
    chk("set_nFault_value", 32'(set_v), 32'(m_v));
    chk("select_error", 32'(sel_err), 32'(m_sel));
    chk("timeout_error", 32'(to_err), 32'(m_to));
    chk("nFault_level", 32'(lvl), 32'(m_level));
    chk("active_channel", 32'(ch), 32'(m_ch));
    chk("fault_status", 32'(status), 32'(m_status));
  end

  // ---------------- stimulus ----------------
  int cz, cv, cs, ct, fz, fv, fs, ft;

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Record pulse counts and the first negedge (1-based) each pulse is seen; drop valid after
  // drop_at cycles.
  task automatic watch(input int n, input int drop_at);
    cz = 0; cv = 0; cs = 0; ct = 0; fz = -1; fv = -1; fs = -1; ft = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (set_z)   begin cz++; if (fz < 0) fz = k; end
      if (set_v)   begin cv++; if (fv < 0) fv = k; end
      if (sel_err) begin cs++; if (fs < 0) fs = k; end
      if (to_err)  begin ct++; if (ft < 0) ft = k; end
      #1;
      if (k == drop_at) valid = 1'b0;
    end
  endtask

  initial begin
    int hold;
    step(3);
    chk("reset_level", 32'(lvl), 32'd1);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_channel", 32'(ch), 32'd0);
    reset = 1'b1;
    step(2);

    // Addressed transaction on channel 2 with a prior fault
    fin = 4'b0100; step(); fin = '0; step();
    chk("fault2_captured", 32'(status), 32'b0100);
    en = 4'b0100; valid = 1'b1;
    watch(10, 5);
    chk("addr_value_cycle", 32'(fv), 32'd6);
    chk("addr_value_count", 32'(cv), 32'd1);
    chk("addr_z_count", 32'(cz), 32'd0);
    chk("addr_channel", 32'(ch), 32'd2);
    chk("addr_level", 32'(lvl), 32'd0);
    step(2);

    // Unaddressed transaction
    en = '0; valid = 1'b1;
    watch(8, 1);
    chk("unaddr_z_cycle", 32'(fz), 32'd5);
    chk("unaddr_z_count", 32'(cz), 32'd1);
    chk("unaddr_value_count", 32'(cv), 32'd0);
    step(2);

    // Multiple enables, valid held high through the drain
    en = 4'b0011; valid = 1'b1;
    watch(14, 12);
    chk("multi_sel_cycle", 32'(fs), 32'd5);
    chk("multi_z_cycle", 32'(fz), 32'd5);
    chk("multi_sel_count", 32'(cs), 32'd1);
    chk("multi_z_count", 32'(cz), 32'd1);
    step(2);

    // Bus hang on channel 0
    en = 4'b0001; valid = 1'b1;
    watch(22, 20);
    chk("timeout_cycle", 32'(ft), 32'd13);
    chk("timeout_count", 32'(ct), 32'd1);
    chk("timeout_z_cycle", 32'(fz), 32'd13);
    chk("timeout_value_count", 32'(cv), 32'd0);
    step(3);

    // Sticky set/clear on channel 1, then a transaction reads it back
    fin = 4'b0010; step(); fin = '0;
    chk("sticky_set", 32'(status[1]), 32'd1);
    fin = 4'b0010; fclr = 4'b0010; step(); fin = '0; fclr = '0;
    chk("sticky_set_wins", 32'(status[1]), 32'd1);
    fclr = 4'b0010; step(); fclr = '0;
    chk("sticky_cleared", 32'(status[1]), 32'd0);
    en = 4'b0010; valid = 1'b1;
    watch(10, 5);
    chk("ch1_value_cycle", 32'(fv), 32'd6);
    chk("ch1_level", 32'(lvl), 32'd1);
    chk("ch1_channel", 32'(ch), 32'd1);
    step(2);

    // Reset while waiting for the bus to go low
    fin = 4'b1000; step(); fin = '0;
    en = 4'b0001; valid = 1'b1;
    step(6);
    reset = 1'b0;
    #1;
    chk("midreset_pulses", {28'd0, set_z, set_v, sel_err, to_err}, 32'd0);
    chk("midreset_level", 32'(lvl), 32'd1);
    chk("midreset_status", 32'(status), 32'd0);
    chk("midreset_channel", 32'(ch), 32'd0);
    valid = 1'b0;
    step(2);
    reset = 1'b1;
    step();
    en = 4'b1000; valid = 1'b1;
    watch(10, 5);
    chk("postreset_value_cycle", 32'(fv), 32'd6);
    chk("postreset_channel", 32'(ch), 32'd3);
    chk("postreset_level", 32'(lvl), 32'd1);
    step(2);

    // Randomized traffic
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold == 0) begin
        valid = ~valid;
        hold = valid ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 4));
      end
      hold--;
      case ($urandom_range(0, 3))
        0:       en = '0;
        1, 2:    en = 4'b0001 << $urandom_range(0, 3);
        default: en = 4'($urandom);
      endcase
      fin  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      fclr = 4'($urandom) & 4'($urandom);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      step();
    end
    reset = 1'b1; valid = 1'b0; en = '0; fin = '0; fclr = '0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nfault_control_fsm.md
# nfault_control_fsm

- Parametrised, multi-channel successor to the single-subsystem nFault state machine.
- Sits between the bus register-address decode and the shared open-drain nFault line:
  - detects a bus transaction and waits a configurable settle time;
  - checks which of NUM_CH subsystems is addressed;
  - releases nFault if none is addressed, or drives it with that channel's latched fault status once the transaction ends.
- Adds behaviour the single-channel machine lacks: sticky per-channel fault capture with clear, detection of multiple enables, and a bus-hang timeout.

## Interface
Parameters:
- NUM_CH, 4, number of subsystems (1..16)
- SETTLE_CYCLES, 1, cycles spent in S_SETTLE before enables are sampled (>=1)
- TIMEOUT_CYCLES, 1024, max cycles in S_WAIT_LOW before timeout; 0 disables timeout

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all registers to reset values
- register_address_valid  in  1  bus transaction in progress
- subsystem_enable  in  NUM_CH  per-channel address-decode enables
- fault_in  in  NUM_CH  per-channel fault level, sampled every cycle
- fault_clear  in  NUM_CH  per-channel clear pulse for sticky fault
- set_nFault_z  out  1  one-cycle pulse: release nFault to 'z
- set_nFault_value  out  1  one-cycle pulse: drive nFault with nFault_level
- nFault_level  out  1  value to drive on nFault (0 = fault present)
- fault_status  out  NUM_CH  sticky fault flags
- active_channel  out  $clog2(NUM_CH) (min 1)  index of last selected channel
- select_error  out  1  one-cycle pulse: more than one enable set
- timeout_error  out  1  one-cycle pulse: register_address_valid stuck high

## Operation
States and transitions (Moore; all outputs decode from state except the registered values below):
- S_IDLE:
  - register_address_valid=1 -> S_SETTLE (settle counter cleared);
  - else stay.
- S_SETTLE:
  - count SETTLE_CYCLES cycles -> S_CHECK;
  - register_address_valid ignored.
- S_CHECK, sample subsystem_enable:
  - zero bits set -> S_RELEASE;
  - exactly one set -> S_WAIT_LOW; active_channel <= index; timeout counter cleared;
  - more than one set -> S_ERROR.
- S_RELEASE: set_nFault_z=1 -> S_IDLE.
- S_WAIT_LOW:
  - register_address_valid=0 -> S_DRIVE; nFault_level <= ~fault_status[active_channel] on that edge;
  - else, if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 -> S_TIMEOUT;
  - else stay and increment the counter.
- S_DRIVE: set_nFault_value=1 -> S_IDLE.
- S_ERROR: select_error=1, set_nFault_z=1 -> S_DRAIN.
- S_TIMEOUT: timeout_error=1, set_nFault_z=1 -> S_DRAIN.
- S_DRAIN:
  - register_address_valid=0 -> S_IDLE;
  - else stay.
  - No timeout applies here.
- Illegal or unencoded state -> S_IDLE.

Sticky faults (independent of the FSM, per channel i, every cycle):
- fault_in[i]=1 -> fault_status[i] <= 1.
- fault_clear[i]=1 with fault_in[i]=0 -> fault_status[i] <= 0.
- Simultaneous fault_in and fault_clear: set wins.

Reset values:
- state S_IDLE.
- All pulse outputs 0.
- nFault_level 1.
- fault_status 0.
- active_channel 0.
- All counters 0.

## Timing
- Take edge E as the one where S_IDLE samples register_address_valid=1:
  - S_SETTLE occupies cycles E+1..E+SETTLE_CYCLES;
  - S_CHECK occupies cycle E+SETTLE_CYCLES+1.
- Unaddressed case: set_nFault_z is high for exactly the cycle after S_CHECK.
- Addressed case:
  - set_nFault_value goes high the cycle after the edge that samples register_address_valid=0 in S_WAIT_LOW;
  - nFault_level is already valid in that cycle and holds until the next S_DRIVE or reset.
- Minimum re-trigger gap: one S_IDLE cycle after S_RELEASE, S_DRIVE or S_DRAIN.
- A fault arriving in the same cycle that S_WAIT_LOW exits is not reflected in nFault_level: it is sampled from the registered fault_status.
- Reset mid-transaction: asynchronous return to S_IDLE; pulses drop immediately, with no completion pulse.

## Test plan
- Single addressed transaction:
  - Setup: NUM_CH=4, SETTLE_CYCLES=1, enable=4'b0100, fault_in[2] pulsed earlier, register_address_valid high 6 cycles.
  - Required: active_channel=2, nFault_level=0, one set_nFault_value pulse 1 cycle after the low is sampled.
- Unaddressed transaction:
  - Setup: enable=0, SETTLE_CYCLES=3.
  - Required: set_nFault_z pulses once, 5 cycles after the sampling edge E; set_nFault_value never pulses.
- Multiple enables:
  - Setup: enable=4'b0011.
  - Required: select_error and set_nFault_z pulse together for one cycle; no further pulse while register_address_valid stays high; return to S_IDLE after it falls.
- Timeout:
  - Setup: TIMEOUT_CYCLES=8, register_address_valid held high 20 cycles.
  - Required: timeout_error pulses once, 8 cycles after S_WAIT_LOW entry; no set_nFault_value.
- Sticky clear:
  - Stimulus: fault_in[1] pulse -> fault_status[1]=1; then fault_clear[1] together with fault_in[1]=1 -> stays 1; then fault_clear[1] alone -> 0.
  - Required: a subsequent transaction on channel 1 gives nFault_level=1.
- Reset asserted in S_WAIT_LOW:
  - Required: all outputs at reset values within the same cycle; fault_status cleared; next transaction proceeds normally.
